// File: rtl/regfile_2r1w_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w_if
// Description : Bundle of the register file's read, write and scoreboard
//               reserve signals. The master modport drives requests. The
//               slave modport (the register file) returns registered read
//               data, busy flags and the read-valid strobe.
//               Signals:
//                 rd_en, rs1_addr, rs2_addr    read request, both ports
//                 rs1_data, rs2_data           registered read data
//                 rs1_busy, rs2_busy           registered scoreboard state
//                 rd_valid                     one cycle after accepted read
//                 wr_en, wr_addr, wr_data      write port
//                 rsv_en, rsv_addr             scoreboard reserve
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_2r1w_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            rd_en;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_valid;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;

    modport master (
        output rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, rd_valid
    );

    modport slave (
        input  rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : Two-read / one-write register file with a per-register
//               scoreboard (busy bit). Register 0 reads as zero and is never
//               written or reserved. Addresses >= NREGS read as zero and are
//               not busy. Reads have one cycle of latency.
//               Macro REGFILE_BYPASS_EN: when defined, a read that hits the
//               register being written in the same cycle returns the write
//               data with busy cleared. When undefined, it returns the
//               pre-write value and busy state.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - regfile_2r1w_if.slave (read/write/reserve bundle)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input wire              clk,
    input wire              rst,
    regfile_2r1w_if.slave   bus
);

    // Storage exists only for registers 1..NREGS-1; x0 is hardwired zero.
    logic [XLEN-1:0] r_regs [NREGS-1:1];
    logic            r_busy [NREGS-1:1];

    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic            r_rs1_busy;
    logic            r_rs2_busy;
    logic            r_rd_valid;

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_rs1_busy;
    logic            w_rs2_busy;

    // ------------------------------------------------------------------------
    // Register and scoreboard update. Decoding by equality against each
    // implemented index makes x0 and out-of-range addresses fall through
    // with no effect. A reserve beats a same-cycle write clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
                r_busy[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
                    r_regs[i] <= bus.wr_data;
                end
                if (bus.rsv_en && (bus.rsv_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read lookup for both ports. Unmatched addresses (x0, >= NREGS) keep
    // the zero defaults. Same-cycle reserves are not visible here because
    // they only reach r_busy on the edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rs1_data = '0;
        w_rs1_busy = 1'b0;
        w_rs2_data = '0;
        w_rs2_busy = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (bus.rs1_addr == AW'(i)) begin
                w_rs1_data = r_regs[i];
                w_rs1_busy = r_busy[i];
`ifdef REGFILE_BYPASS_EN
                if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
                    w_rs1_data = bus.wr_data;
                    w_rs1_busy = 1'b0;
                end
`endif
            end
            if (bus.rs2_addr == AW'(i)) begin
                w_rs2_data = r_regs[i];
                w_rs2_busy = r_busy[i];
`ifdef REGFILE_BYPASS_EN
                if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
                    w_rs2_data = bus.wr_data;
                    w_rs2_busy = 1'b0;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered read outputs: captured only on an accepted read, held
    // otherwise. The valid strobe follows rd_en by one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1_busy <= 1'b0;
            r_rs2_busy <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_rs1_busy <= w_rs1_busy;
                r_rs2_busy <= w_rs2_busy;
            end
        end
    end

    assign bus.rs1_data = r_rs1_data;
    assign bus.rs2_data = r_rs2_data;
    assign bus.rs1_busy = r_rs1_busy;
    assign bus.rs2_busy = r_rs2_busy;
    assign bus.rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2r1w
// Description : Self-checking bench for regfile_2r1w (NREGS=24, so that
//               addresses 24..31 are out of range). A reference model
//               computes each read's expected result when the read is
//               driven and queues it. A negedge monitor pops the result when
//               rd_valid is due and otherwise checks that outputs hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic            b1;
        logic            b2;
    } exp_t;

    logic clk;
    logic rst;
    regfile_2r1w_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t last;
    logic tb_vld;
    logic [XLEN-1:0] m_regs [32];
    logic            m_busy [32];

    task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference read of one port from the model's pre-edge state.
    task automatic model_rd(input logic [AW-1:0] a, input logic we, input logic [AW-1:0] wa,
                            input logic [XLEN-1:0] wd, output logic [XLEN-1:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (a != 0 && int'(a) < NREGS) begin
            d = m_regs[a];
            b = m_busy[a];
            if (BYP && we && wa == a) begin
                d = wd;
                b = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        sb_q.delete();
        last = '0;
    endtask

    // Drive one cycle of stimulus at posedge+2, capture at the next posedge.
    task automatic cycle(input logic rd, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic rs, input logic [AW-1:0] ra);
        exp_t e;
        if (rd) begin
            model_rd(a1, we, wa, wd, e.d1, e.b1);
            model_rd(a2, we, wa, wd, e.d2, e.b2);
            sb_q.push_back(e);
        end
        if (we && wa != 0 && int'(wa) < NREGS) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (rs && ra != 0 && int'(ra) < NREGS) m_busy[ra] = 1'b1;
        bus.rd_en    = rd;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rsv_en   = rs;
        bus.rsv_addr = ra;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        cycle(1'b1, a1, a2, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        cycle(1'b0, '0, '0, 1'b1, wa, wd, 1'b0, '0);
    endtask

    // Assert reset asynchronously, check outputs clear at once, release.
    task automatic do_reset();
        rst = 1'b1;
        bus.rd_en  = 1'b0;
        bus.wr_en  = 1'b0;
        bus.rsv_en = 1'b0;
        #1;
        chk("rst_rs1_data", bus.rs1_data, '0);
        chk("rst_rs2_data", bus.rs2_data, '0);
        chk("rst_rs1_busy", {31'd0, bus.rs1_busy}, '0);
        chk("rst_rs2_busy", {31'd0, bus.rs2_busy}, '0);
        chk("rst_valid",    {31'd0, bus.rd_valid}, '0);
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Expected valid strobe: one cycle after rd_en is sampled.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_vld <= 1'b0;
        else     tb_vld <= bus.rd_en;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, tb_vld});
            if (tb_vld) begin
                chk("sb_level", sb_q.size() > 0 ? 32'd1 : 32'd0, 32'd1);
                if (sb_q.size() > 0) last = sb_q.pop_front();
            end
            chk("rs1_data", bus.rs1_data, last.d1);
            chk("rs2_data", bus.rs2_data, last.d2);
            chk("rs1_busy", {31'd0, bus.rs1_busy}, {31'd0, last.b1});
            chk("rs2_busy", {31'd0, bus.rs2_busy}, {31'd0, last.b2});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_en = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0;  bus.wr_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #2;
        do_reset();
        idle();

        // Basic write then read, second port on x0.
        wr(5'd3, 32'h1234_5678);
        rd(5'd3, 5'd0);
        idle();
        idle();

        // Same-cycle write/read of x7 (bypass-dependent), then read-back.
        wr(5'd7, 32'h0000_0001);
        cycle(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0);
        rd(5'd7, 5'd3);

        // Scoreboard sequence on x9.
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        rd(5'd9, 5'd9);
        cycle(1'b0, '0, '0, 1'b1, 5'd9, 32'h5, 1'b1, 5'd9);
        rd(5'd9, 5'd3);
        wr(5'd9, 32'h5);
        rd(5'd9, 5'd9);

        // Same-cycle reserve is not visible to a same-cycle read.
        cycle(1'b1, 5'd11, 5'd11, 1'b0, '0, '0, 1'b1, 5'd11);
        rd(5'd11, 5'd0);

        // x0 and out-of-range: writes/reserves ignored, reads are zero.
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
        cycle(1'b0, '0, '0, 1'b1, 5'd30, 32'hFFFF_FFFF, 1'b1, 5'd30);
        rd(5'd30, 5'd0);
        rd(5'd0, 5'd30);
        idle();

        // Randomised traffic over the full address space.
        for (int k = 0; k < 80; k++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        idle();

        // Reset mid-read after writing x5, then x5 must read back zero.
        wr(5'd5, 32'hDEAD_BEEF);
        rd(5'd5, 5'd5);
        do_reset();
        rd(5'd5, 5'd5);
        idle();
        idle();

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
